// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, sample pair type and capture FSM states for the FFT output capture path.
package fft_pkg;
    localparam int N  = 1024;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);
    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } sample_t;
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} cap_state_t;
endpackage

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port RAM, one write port and one read port with registered read data.
module capture_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int W     = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fft_out_capture.sv
// fft_out_capture: buffers one FFT1024 output frame and replays it over a ready/valid stream with bin index and last flag.
module fft_out_capture
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fft_done,
    input  logic signed [DW-1:0] fft_re,
    input  logic signed [DW-1:0] fft_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic [AW-1:0]        out_idx,
    output logic                 out_last,
    output logic                 busy,
    output logic                 overrun
);
    cap_state_t state, state_d;
    logic [AW-1:0] wptr, rptr, ridx;
    logic pend, rv, adv, ren, xfer;
    sample_t wdata, rdata;

    assign wdata = '{re: fft_re, im: fft_im};
    assign busy  = state != IDLE;
    assign xfer  = out_valid && out_ready;
    assign adv   = !out_valid || out_ready;
    // RAM read data acts as the second pipeline stage; it only advances when the output register can take it
    assign ren   = state == DRAIN && pend && (adv || !rv);

    capture_ram #(.DEPTH(N), .AW(AW), .W(2 * DW)) u_ram (
        .clk   (clk),
        .we    (state == CAPTURE),
        .waddr (wptr),
        .wdata (wdata),
        .re    (ren),
        .raddr (rptr),
        .rdata (rdata)
    );

    always_comb begin
        state_d = (state == IDLE && fft_done) ? CAPTURE :
                  (state == CAPTURE && wptr == IDX_LAST) ? DRAIN :
                  (state == DRAIN && xfer && out_last) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            ridx      <= '0;
            pend      <= 1'b0;
            rv        <= 1'b0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= overrun | (fft_done && state != IDLE);
            wptr    <= (state == CAPTURE) ? wptr + 1'b1 : '0;
            if (state != DRAIN) begin
                rptr <= '0;
                pend <= 1'b1;
                rv   <= 1'b0;
            end else begin
                if (ren) begin
                    rptr <= rptr + 1'b1;
                    ridx <= rptr;
                    pend <= rptr != IDX_LAST;
                end
                if (adv || !rv) rv <= ren;
            end
            if (adv) begin
                out_valid <= rv;
                if (rv) begin
                    out_re   <= rdata.re;
                    out_im   <= rdata.im;
                    out_idx  <= ridx;
                    out_last <= ridx == IDX_LAST;
                end
            end
        end
    end
endmodule

// File: tb/tb_fft_out_capture.sv
// tb_fft_out_capture: scoreboard bench; expected samples are queued as frames are driven and checked at each handshake.
module tb_fft_out_capture;
    localparam int N = 1024;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        int          idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fft_done = 1'b0;
    logic [15:0] fft_re = '0;
    logic [15:0] fft_im = '0;
    logic        out_ready = 1'b0;
    logic        out_valid, out_last, busy, overrun;
    logic [15:0] out_re, out_im;
    logic [9:0]  out_idx;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0, mode = 0, last_cap_cyc = 0;
    logic prev_stall = 1'b0, seen_valid = 1'b0;

    fft_out_capture dut (
        .clk       (clk),
        .rst       (rst),
        .fft_done  (fft_done),
        .fft_re    (fft_re),
        .fft_im    (fft_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_re", out_re, 0);
        chk("rst_im", out_im, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
    endtask

    // One clock: drive inputs, check visible outputs against the scoreboard, then advance past the edge.
    task automatic step(input logic d, input logic [15:0] r, input logic [15:0] m, input logic rs);
        exp_t e;
        cyc++;
        fft_done  = d;
        fft_re    = r;
        fft_im    = m;
        rst       = rs;
        out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 4 == 0) : 1'($urandom_range(0, 1));
        if (prev_stall) chk("hold_valid", out_valid, 1);
        if (out_valid) begin
            if (!seen_valid) begin
                chk("first_valid_lat", cyc - last_cap_cyc, 3);
                seen_valid = 1'b1;
            end
            if (sb.size() == 0) chk("extra_out", out_valid, 0);
            else begin
                e = sb[0];
                chk("out_re", out_re, e.re);
                chk("out_im", out_im, e.im);
                chk("out_idx", out_idx, e.idx);
                chk("out_last", out_last, e.idx == N - 1);
                if (out_ready && !rs) void'(sb.pop_front());
            end
        end
        prev_stall = out_valid && !out_ready && !rs;
        @(posedge clk);
        #1;
    endtask

    // kind: 0 ramp, 1 signed extremes, 2 random
    task automatic frame(input int kind, input int done_at, input int rst_at);
        logic [15:0] r, m;
        chk("pre_busy", busy, 0);
        seen_valid = 1'b0;
        step(1'b1, '0, '0, 1'b0);
        for (int i = 0; i < N; i++) begin
            r = (kind == 0) ? 16'(i) : (kind == 1) ? (i[0] ? 16'h8000 : 16'h7FFF) : 16'($urandom);
            m = (kind == 0) ? 16'(-i) : (kind == 1) ? (i[0] ? 16'h7FFF : 16'h8000) : 16'($urandom);
            if (i == rst_at) begin
                step(1'b0, r, m, 1'b1);
                sb.delete();
                chk_reset();
                return;
            end
            sb.push_back('{re: r, im: m, idx: i});
            step(i == done_at, r, m, 1'b0);
        end
        last_cap_cyc = cyc;
        chk("busy_cap", busy, 1);
    endtask

    task automatic drain(input int done_at, input int rst_idx);
        int  n = 0;
        logic rs;
        while (sb.size() > 0 && n < 20000) begin
            rs = rst_idx >= 0 && out_valid && out_idx == 10'(rst_idx);
            step(n == done_at, 16'($urandom), 16'($urandom), rs);
            n++;
            if (rs) begin
                sb.delete();
                chk_reset();
                return;
            end
        end
        if (sb.size() > 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        chk("busy_end", busy, 0);
        chk("valid_end", out_valid, 0);
    endtask

    initial begin
        repeat (3) step(1'b0, '0, '0, 1'b1);
        chk_reset();
        mode = 0;
        frame(0, -1, -1);
        drain(-1, -1);
        chk("ovr_clean", overrun, 0);
        mode = 1;
        frame(0, -1, -1);
        drain(-1, -1);
        mode = 2;
        frame(0, -1, -1);
        drain(-1, -1);
        mode = 0;
        frame(0, 500, -1);
        chk("ovr_capture", overrun, 1);
        drain(100, -1);
        chk("ovr_drain", overrun, 1);
        frame(2, -1, -1);
        drain(-1, -1);
        chk("ovr_sticky", overrun, 1);
        step(1'b0, '0, '0, 1'b1);
        chk_reset();
        frame(0, -1, -1);
        drain(-1, -1);
        frame(1, -1, -1);
        chk("b2b_ovr", overrun, 0);
        drain(-1, -1);
        chk("b2b_ovr_end", overrun, 0);
        frame(0, -1, 300);
        frame(0, -1, -1);
        drain(-1, 600);
        mode = 2;
        frame(2, -1, -1);
        drain(-1, -1);
        mode = 0;
        for (int i = 0; i < 2000; i++) begin
            step(1'b0, 16'($urandom), 16'($urandom), 1'b0);
            chk("idle_valid", out_valid, 0);
            chk("idle_busy", busy, 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
